benes_cfg_sequencer: RTL and testbench

- Upstream control stage for the dual Benes interconnect: stores precomputed switch-setting words for the RAM-to-module and module-to-RAM networks.
- On command, plays a run of consecutive entries, one entry per REPEAT cycles, onto the interconnect's module-select and slot-select inputs.
- Emits a valid flag aligned to the selects, plus a copy delayed by the interconnect latency, so downstream logic knows when routed data is present.

---
 rtl/benes_cfg_pkg.sv | 16 +
 rtl/benes_cfg_sequencer_delay.sv | 15 +
 rtl/benes_cfg_sequencer.sv | 137 +++++++++++++
 tb/tb_benes_cfg_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/benes_cfg_pkg.sv
// benes_cfg_pkg: shared state encoding, config-word type and flat-to-packed mapping for the Benes config sequencer
package benes_cfg_pkg;
  localparam int PKG_SWITCH_NUM = 16;
  localparam int PKG_STAGE_NUM = 9;
  localparam int PKG_CFG_W = PKG_STAGE_NUM * PKG_SWITCH_NUM;
  localparam int NET_LAT_DEF = 11;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [0:PKG_STAGE_NUM-1][0:PKG_SWITCH_NUM-1] cfg_word_t;
  function automatic cfg_word_t to_cfg(input logic [PKG_CFG_W-1:0] flat);
    cfg_word_t r;
    for (int s = 0; s < PKG_STAGE_NUM; s++)
      for (int w = 0; w < PKG_SWITCH_NUM; w++)
        r[s][w] = flat[s*PKG_SWITCH_NUM+w];
    return r;
  endfunction
endpackage

// File: rtl/benes_cfg_sequencer_delay.sv
// valid_delay_line: DEPTH-stage async-reset shift register that delays a 1-bit valid
module valid_delay_line #(
  parameter int DEPTH = 11
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) sr <= '0;
    else sr <= {sr[DEPTH-2:0], din};
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/benes_cfg_sequencer.sv
// benes_cfg_sequencer: plays stored switch-setting runs onto the dual Benes interconnect selects.
// Optional BENES_CFG_PARITY_EN adds per-entry even parity and a sticky O_PARITY_ERR port.
module benes_cfg_sequencer import benes_cfg_pkg::*; #(
  parameter int SWITCH_NUM = PKG_SWITCH_NUM,
  parameter int STAGE_NUM  = PKG_STAGE_NUM,
  parameter int CFG_W      = STAGE_NUM * SWITCH_NUM,
  parameter int CFG_DEPTH  = 16,
  parameter int CFG_AW     = $clog2(CFG_DEPTH),
  parameter int LEN_W      = 8,
  parameter int NET_LAT    = NET_LAT_DEF
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  I_CFG_WE,
  input  logic                                  I_CFG_NET,
  input  logic [CFG_AW-1:0]                     I_CFG_ADDR,
  input  logic [CFG_W-1:0]                      I_CFG_DATA,
  input  logic                                  I_START,
  input  logic [CFG_AW-1:0]                     I_START_ADDR,
  input  logic [LEN_W-1:0]                      I_LEN,
  input  logic [LEN_W-1:0]                      I_REPEAT,
  input  logic                                  I_HOLD,
  output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]  O_MODULE_SELECT,
  output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]  O_SLOT_SELECT,
  output logic                                  O_SEL_VALID,
  output logic [CFG_AW-1:0]                     O_ENTRY_IDX,
  output logic                                  O_DATA_VALID,
  output logic                                  O_BUSY,
  output logic                                  O_DONE
`ifdef BENES_CFG_PARITY_EN
  ,
  output logic                                  O_PARITY_ERR
`endif
);
  state_t state, state_n;
  logic [CFG_AW-1:0] addr, addr_n;
  logic [LEN_W-1:0] len_cnt, len_n, rep, rep_n, rep_cnt, rep_cnt_n, dcnt, dcnt_n;
  logic [CFG_W-1:0] mod_q, slot_q;
  logic [CFG_W-1:0] mod_tab [CFG_DEPTH];
  logic [CFG_W-1:0] slot_tab [CFG_DEPTH];
  logic start_ok, fetch;

  assign start_ok = state == IDLE && I_START;
  // A held RUN cycle keeps the already-fetched word; everything else entering/staying in RUN fetches
  assign fetch = state_n == RUN && !(state == RUN && I_HOLD);

  always_comb begin
    state_n = state;
    addr_n = addr;
    len_n = len_cnt;
    rep_n = rep;
    rep_cnt_n = rep_cnt;
    dcnt_n = dcnt;
    case (state)
      IDLE: if (I_START) begin
        state_n = I_LEN == '0 ? DONE : RUN;
        addr_n = I_START_ADDR;
        len_n = I_LEN;
        rep_n = I_REPEAT == '0 ? LEN_W'(1) : I_REPEAT;
        rep_cnt_n = rep_n;
      end
      RUN: if (!I_HOLD) begin
        if (rep_cnt > LEN_W'(1)) rep_cnt_n = rep_cnt - LEN_W'(1);
        else if (len_cnt > LEN_W'(1)) begin
          addr_n = addr + CFG_AW'(1);
          len_n = len_cnt - LEN_W'(1);
          rep_cnt_n = rep;
        end else begin
          state_n = DRAIN;
          dcnt_n = LEN_W'(NET_LAT - 1);
        end
      end
      DRAIN: begin
        state_n = dcnt == '0 ? DONE : DRAIN;
        dcnt_n = dcnt == '0 ? dcnt : dcnt - LEN_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      addr <= '0;
      len_cnt <= '0;
      rep <= '0;
      rep_cnt <= '0;
      dcnt <= '0;
      mod_q <= '0;
      slot_q <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      len_cnt <= len_n;
      rep <= rep_n;
      rep_cnt <= rep_cnt_n;
      dcnt <= dcnt_n;
      mod_q <= fetch ? mod_tab[addr_n] : mod_q;
      slot_q <= fetch ? slot_tab[addr_n] : slot_q;
    end

  // Tables are not reset; the fetch above sees the pre-write contents of this edge
  always_ff @(posedge CLK)
    if (I_CFG_WE) begin
      if (I_CFG_NET) slot_tab[I_CFG_ADDR] <= I_CFG_DATA;
      else mod_tab[I_CFG_ADDR] <= I_CFG_DATA;
    end

`ifdef BENES_CFG_PARITY_EN
  logic mod_par [CFG_DEPTH];
  logic slot_par [CFG_DEPTH];
  logic perr;
  assign perr = fetch && ((^mod_tab[addr_n] ^ mod_par[addr_n]) || (^slot_tab[addr_n] ^ slot_par[addr_n]));
  always_ff @(posedge CLK)
    if (I_CFG_WE) begin
      if (I_CFG_NET) slot_par[I_CFG_ADDR] <= ^I_CFG_DATA;
      else mod_par[I_CFG_ADDR] <= ^I_CFG_DATA;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) O_PARITY_ERR <= 1'b0;
    else O_PARITY_ERR <= (O_PARITY_ERR && !start_ok) || perr;
`endif

  assign O_MODULE_SELECT = to_cfg(mod_q);
  assign O_SLOT_SELECT = to_cfg(slot_q);
  assign O_SEL_VALID = state == RUN && !I_HOLD;
  assign O_ENTRY_IDX = addr;
  assign O_BUSY = state != IDLE;
  assign O_DONE = state == DONE;

  valid_delay_line #(.DEPTH(NET_LAT)) u_dly (
    .CLK(CLK),
    .RST_N(RST_N),
    .din(O_SEL_VALID),
    .dout(O_DATA_VALID)
  );
endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// tb_benes_cfg_sequencer: scoreboard bench; stimulus queues expected beats/valids/done, a negedge monitor checks them
module tb_benes_cfg_sequencer;
  localparam int SN = 16, ST = 9, W = SN * ST, D = 16, AW = 4, LW = 8, NL = 11;
  logic CLK = 0, RST_N = 0;
  logic I_CFG_WE = 0, I_CFG_NET = 0;
  logic [AW-1:0] I_CFG_ADDR = '0, I_START_ADDR = '0;
  logic [W-1:0] I_CFG_DATA = '0;
  logic I_START = 0, I_HOLD = 0;
  logic [LW-1:0] I_LEN = '0, I_REPEAT = '0;
  logic [0:ST-1][0:SN-1] O_MODULE_SELECT, O_SLOT_SELECT;
  logic O_SEL_VALID, O_DATA_VALID, O_BUSY, O_DONE;
  logic [AW-1:0] O_ENTRY_IDX;
`ifdef BENES_CFG_PARITY_EN
  logic O_PARITY_ERR;
`endif

  benes_cfg_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_CFG_WE(I_CFG_WE), .I_CFG_NET(I_CFG_NET), .I_CFG_ADDR(I_CFG_ADDR), .I_CFG_DATA(I_CFG_DATA),
    .I_START(I_START), .I_START_ADDR(I_START_ADDR), .I_LEN(I_LEN), .I_REPEAT(I_REPEAT), .I_HOLD(I_HOLD),
    .O_MODULE_SELECT(O_MODULE_SELECT), .O_SLOT_SELECT(O_SLOT_SELECT), .O_SEL_VALID(O_SEL_VALID),
    .O_ENTRY_IDX(O_ENTRY_IDX), .O_DATA_VALID(O_DATA_VALID), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
`ifdef BENES_CFG_PARITY_EN
    , .O_PARITY_ERR(O_PARITY_ERR)
`endif
  );

  typedef struct {int c; logic [AW-1:0] idx; logic [W-1:0] m; logic [W-1:0] s;} beat_t;
  beat_t bq[$];
  int dvq[$];
  int dq[$];
  beat_t mb;
  logic [W-1:0] mod_m [D];
  logic [W-1:0] slot_m [D];
  int cyc = 0, n_cmp = 0, n_err = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [W-1:0] mw(input int i);
    logic [W-1:0] r;
    r = {8'(i * 7 + 3), 136'h0123456789ABCDEF0F1E2D3C4B5A697887};
    return r;
  endfunction
  function automatic logic [W-1:0] sw(input int i);
    logic [W-1:0] a;
    a = mw(i);
    return {a[71:0] ^ 72'(i), a[143:72]};
  endfunction
  // flat bit s*SN+w lands on select [s][w], which is the bit-reversed flat word
  function automatic logic [W-1:0] rev(input logic [W-1:0] f);
    logic [W-1:0] r;
    r = {<<{f}};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) if (RST_N) begin
    if (O_SEL_VALID) begin
      if (bq.size() == 0) chk("unexpected_sel_valid", O_SEL_VALID, 0);
      else begin
        mb = bq.pop_front();
        chk("beat_cycle", cyc, mb.c);
        chk("entry_idx", O_ENTRY_IDX, mb.idx);
        chk("module_select", O_MODULE_SELECT, rev(mb.m));
        chk("slot_select", O_SLOT_SELECT, rev(mb.s));
      end
    end
    if (O_DATA_VALID) begin
      if (dvq.size() == 0) chk("unexpected_data_valid", O_DATA_VALID, 0);
      else chk("data_valid_cycle", cyc, dvq.pop_front());
    end
    if (O_DONE) begin
      if (dq.size() == 0) chk("unexpected_done", O_DONE, 0);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input bit net, input int a, input logic [W-1:0] d);
    I_CFG_WE = 1; I_CFG_NET = net; I_CFG_ADDR = AW'(a); I_CFG_DATA = d;
    tick();
    I_CFG_WE = 0;
    if (net) slot_m[a] = d; else mod_m[a] = d;
  endtask

  // Issues one START and queues the expected beats, data-valids and done; hold window is [c0+hs, c0+hs+hn)
  task automatic run(input int a, input int l, input int r, input int hs = 0, input int hn = 0);
    int c0, t, re, e;
    c0 = cyc;
    re = r == 0 ? 1 : r;
    t = c0 + 1;
    I_START = 1; I_START_ADDR = AW'(a); I_LEN = LW'(l); I_REPEAT = LW'(r);
    for (int k = 0; k < l; k++)
      for (int j = 0; j < re; j++) begin
        if (hn > 0 && t == c0 + hs) t += hn;
        e = (a + k) % D;
        bq.push_back('{t, AW'(e), mod_m[e], slot_m[e]});
        dvq.push_back(t + NL);
        t++;
      end
    dq.push_back(l == 0 ? c0 + 1 : t + NL);
    tick();
    I_START = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bq.size() != 0 || dvq.size() != 0 || dq.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: pending beats=%0d dv=%0d done=%0d, required 0", bq.size(), dvq.size(), dq.size());
      bq.delete(); dvq.delete(); dq.delete();
    end
    tick();
    tick();
    chk("idle_busy", O_BUSY, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_sel_valid", O_SEL_VALID, 0);
    chk("rst_busy", O_BUSY, 0);
    chk("rst_done", O_DONE, 0);
    chk("rst_data_valid", O_DATA_VALID, 0);
    chk("rst_module_select", O_MODULE_SELECT, 0);
    chk("rst_entry_idx", O_ENTRY_IDX, 0);
`ifdef BENES_CFG_PARITY_EN
    chk("rst_parity_err", O_PARITY_ERR, 0);
`endif
    @(posedge CLK); #1;
    RST_N = 1;
    tick();
    foreach (mw_list[i]) begin
      wr(0, mw_list[i], mw(mw_list[i]));
      wr(1, mw_list[i], sw(mw_list[i]));
    end
    run(0, 4, 1);
    drain();
    run(14, 4, 2);
    drain();
    run(0, 4, 1, 3, 3);
    tick();
    tick();
    I_HOLD = 1;
    #3 chk("hold_frozen_a", O_MODULE_SELECT, rev(mod_m[2]));
    tick();
    tick();
    chk("hold_frozen_b", O_SLOT_SELECT, rev(slot_m[2]));
    chk("hold_sel_valid", O_SEL_VALID, 0);
    tick();
    I_HOLD = 0;
    drain();
    run(5, 0, 3);
    drain();
    run(0, 4, 1);
    tick();
    I_START = 1; I_START_ADDR = AW'(9); I_LEN = LW'(1);
    wr(0, 2, ~mw(2));
    I_START = 0;
    tick();
    tick();
    tick();
    I_HOLD = 1;
    tick();
    I_HOLD = 0;
    drain();
    run(2, 1, 1);
    drain();
    run(0, 4, 2);
    while (bq.size() > 3) void'(bq.pop_back());
    dvq.delete();
    dq.delete();
    tick();
    tick();
    tick();
    #2 RST_N = 0;
    #1;
    chk("arst_sel_valid", O_SEL_VALID, 0);
    chk("arst_busy", O_BUSY, 0);
    chk("arst_entry_idx", O_ENTRY_IDX, 0);
    chk("arst_module_select", O_MODULE_SELECT, 0);
    chk("arst_slot_select", O_SLOT_SELECT, 0);
    chk("arst_done", O_DONE, 0);
    chk("arst_beats_left", bq.size(), 0);
    tick();
    tick();
    RST_N = 1;
    repeat (20) tick();
    chk("post_rst_busy", O_BUSY, 0);
`ifdef BENES_CFG_PARITY_EN
    wr(0, 5, mw(5));
    wr(1, 5, sw(5));
    force dut.mod_tab[5] = mw(5) ^ 144'd1;
    mod_m[5] = mw(5) ^ 144'd1;
    run(5, 1, 1);
    drain();
    chk("parity_err_set", O_PARITY_ERR, 1);
    release dut.mod_tab[5];
    wr(0, 5, mw(5));
    repeat (3) tick();
    chk("parity_err_sticky", O_PARITY_ERR, 1);
    run(0, 1, 1);
    drain();
    chk("parity_err_clear", O_PARITY_ERR, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  int mw_list[6] = '{0, 1, 2, 3, 14, 15};
endmodule
